fpu_issue_unit: RTL and testbench

//  Initiator side of the FPU operand/opcode interface: accepts one operation per valid/ready

---
 rtl/fpu_issue_unit.sv | 144 ++++++++++++++
 tb/tb_fpu_issue_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_unit.sv
// fpu_issue_unit: issues one FPU op at a time and holds its operands
// for the op's fixed latency, then returns the captured result.
module fpu_issue_unit #(
  parameter int LAT_ADD = 4,
  parameter int LAT_SUB = 4,
  parameter int LAT_MUL = 6,
  parameter int LAT_DIV = 30,
  parameter int LAT_CMP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_opc,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [2:0]  fpu_opc,
  input  logic [31:0] fpu_out,
  input  logic        fpu_aeb,
  input  logic        fpu_alb,
  input  logic        fpu_agb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_aeb,
  output logic        rsp_alb,
  output logic        rsp_agb,
  output logic        rsp_err,
  output logic        busy
);

  localparam int M1 = (LAT_ADD > LAT_SUB) ? LAT_ADD : LAT_SUB;
  localparam int M2 = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int LMAX = (M3 > LAT_CMP) ? M3 : LAT_CMP;
  localparam int CW = $clog2(LMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_sel;
  logic          legal;
  logic          accept;
  logic          is_cmp;
  logic          op_add;
  logic          op_sub;
  logic          op_mul;
  logic          op_div;
  logic          op_cmp;

  assign op_add = (req_opc == 3'd0);
  assign op_sub = (req_opc == 3'd1);
  assign op_mul = (req_opc == 3'd2);
  assign op_div = (req_opc == 3'd3);
  assign op_cmp = (req_opc == 3'd4);
  assign legal  = op_add | op_sub | op_mul | op_div | op_cmp;
  assign accept = req_valid & req_ready;
  assign is_cmp = (fpu_opc == 3'd4);

  always_comb begin
    lat_sel = '0;
    unique case (1'b1)
      op_add:  lat_sel = CW'(LAT_ADD);
      op_sub:  lat_sel = CW'(LAT_SUB);
      op_mul:  lat_sel = CW'(LAT_MUL);
      op_div:  lat_sel = CW'(LAT_DIV);
      op_cmp:  lat_sel = CW'(LAT_CMP);
      default: lat_sel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_opc   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_aeb   <= 1'b0;
      rsp_alb   <= 1'b0;
      rsp_agb   <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (legal) begin
              fpu_a   <= req_a;
              fpu_b   <= req_b;
              fpu_opc <= req_opc;
              cnt     <= lat_sel;
              state   <= WAIT;
            end else begin
              // illegal ops skip the core entirely
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_aeb   <= 1'b0;
              rsp_alb   <= 1'b0;
              rsp_agb   <= 1'b0;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= is_cmp ? 32'd0 : fpu_out;
            rsp_aeb   <= is_cmp & fpu_aeb;
            rsp_alb   <= is_cmp & fpu_alb;
            rsp_agb   <= is_cmp & fpu_agb;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_unit.sv
// tb_fpu_issue_unit: random and directed checks of fpu_issue_unit
// against a latency/handshake reference model.
module tb_fpu_issue_unit;

  localparam int LA = 4;
  localparam int LS = 4;
  localparam int LM = 6;
  localparam int LD = 30;
  localparam int LC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_opc = '0;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [2:0]  fpu_opc;
  logic [31:0] fpu_out = '0;
  logic        fpu_aeb = 1'b0;
  logic        fpu_alb = 1'b0;
  logic        fpu_agb = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_aeb;
  logic        rsp_alb;
  logic        rsp_agb;
  logic        rsp_err;
  logic        busy;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  logic [31:0] hout[int];
  logic [2:0]  hflg[int];

  bit          frc = 1'b0;
  logic [31:0] frc_out = '0;
  logic [2:0]  frc_flg = '0;

  logic [31:0] exp_fa = '0;
  logic [31:0] exp_fb = '0;
  logic [2:0]  exp_fo = '0;

  fpu_issue_unit #(
    .LAT_ADD(LA), .LAT_SUB(LS), .LAT_MUL(LM),
    .LAT_DIV(LD), .LAT_CMP(LC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opc(req_opc),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opc(fpu_opc),
    .fpu_out(fpu_out), .fpu_aeb(fpu_aeb),
    .fpu_alb(fpu_alb), .fpu_agb(fpu_agb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_aeb(rsp_aeb),
    .rsp_alb(rsp_alb), .rsp_agb(rsp_agb),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // history of what the core presented at each rising edge
  always @(posedge clk) begin
    hout[cyc] = fpu_out;
    hflg[cyc] = {fpu_aeb, fpu_alb, fpu_agb};
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (frc) begin
      fpu_out = frc_out;
      {fpu_aeb, fpu_alb, fpu_agb} = frc_flg;
    end else begin
      fpu_out = $urandom;
      {fpu_aeb, fpu_alb, fpu_agb} = 3'($urandom);
    end
  end

  function automatic int latf(input logic [2:0] op);
    case (op)
      3'd0: return LA;
      3'd1: return LS;
      3'd2: return LM;
      3'd3: return LD;
      3'd4: return LC;
      default: return 0;
    endcase
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int bp,
                       input bit keep, output int acc);
    int n;
    int lat;
    bit legal;
    logic [31:0] ed;
    logic [2:0]  ef;
    logic [31:0] hd;
    logic [3:0]  hf;
    acc = -1;
    req_a = a;
    req_b = b;
    req_opc = op;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (n >= 200) begin
      errs++;
      $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req_a = $urandom;
    req_b = $urandom;
    req_opc = 3'($urandom);
    legal = (op < 3'd5);
    if (legal) begin
      exp_fa = a;
      exp_fb = b;
      exp_fo = op;
    end
    lat = latf(op);
    vec++;
    if ({fpu_a, fpu_b, fpu_opc} !== {exp_fa, exp_fb, exp_fo}) begin
      errs++;
      $display("FAIL fpu_drive: got %h/%h/%h want %h/%h/%h",
               fpu_a, fpu_b, fpu_opc, exp_fa, exp_fb, exp_fo);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      vec++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errs++;
        $display("FAIL wait_status: busy=%b ready=%b want 1/0",
                 busy, req_ready);
      end
      rsp_ready = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    vec++;
    if (n != lat) begin
      errs++;
      $display("FAIL latency: op=%0d got %0d edges want %0d", op, n, lat);
    end
    ed = (legal && op != 3'd4) ? hout[acc+lat] : 32'd0;
    ef = (op == 3'd4) ? hflg[acc+lat] : 3'd0;
    vec++;
    if ({rsp_data, rsp_aeb, rsp_alb, rsp_agb, rsp_err} !==
        {ed, ef, !legal}) begin
      errs++;
      $display("FAIL rsp: op=%0d got %h %b%b%b e%b want %h %b e%b",
               op, rsp_data, rsp_aeb, rsp_alb, rsp_agb, rsp_err,
               ed, ef, !legal);
    end
    hd = rsp_data;
    hf = {rsp_aeb, rsp_alb, rsp_agb, rsp_err};
    repeat (bp) begin
      @(posedge clk);
      @(negedge clk);
      vec++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== hd ||
          {rsp_aeb, rsp_alb, rsp_agb, rsp_err} !== hf) begin
        errs++;
        $display("FAIL backpressure: v=%b rdy=%b d=%h want 1/0/%h",
                 rsp_valid, req_ready, rsp_data, hd);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (!keep) req_valid = 1'b0;
    vec++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errs++;
      $display("FAIL handshake: v/rdy/busy=%b%b%b want 010",
               rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({req_ready, fpu_a, fpu_b, fpu_opc, rsp_valid, rsp_data, rsp_aeb,
         rsp_alb, rsp_agb, rsp_err, busy} !== '0) begin
      errs++;
      $display("FAIL reset_vals: ready=%b v=%b busy=%b want 0",
               req_ready, rsp_valid, busy);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (req_ready !== 1'b0) begin
      errs++;
      $display("FAIL ready_pre_edge: got %b want 0", req_ready);
    end
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ready_post_edge: rdy=%b busy=%b want 1/0",
               req_ready, busy);
    end
  endtask

  task automatic test_add;
    int acc;
    frc = 1'b1;
    frc_out = 32'h40400000;
    frc_flg = 3'b000;
    @(negedge clk);
    do_op(32'h3F800000, 32'h40000000, 3'd0, 0, 1'b0, acc);
    vec++;
    if (rsp_data !== 32'h40400000 || rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL add_data: got %h err %b want 40400000 err 0",
               rsp_data, rsp_err);
    end
  endtask

  task automatic test_compare;
    int acc;
    frc_out = 32'h12345678;
    frc_flg = 3'b001;
    @(negedge clk);
    do_op(32'h40000000, 32'h3F800000, 3'd4, 1, 1'b0, acc);
    vec++;
    if ({rsp_data, rsp_aeb, rsp_alb, rsp_agb} !== {32'd0, 3'b001}) begin
      errs++;
      $display("FAIL cmp_flags: got %h %b%b%b want 0 001",
               rsp_data, rsp_aeb, rsp_alb, rsp_agb);
    end
    frc = 1'b0;
  endtask

  task automatic test_illegal;
    int acc;
    for (int k = 5; k < 8; k++)
      do_op($urandom, $urandom, 3'(k), k - 5, 1'b0, acc);
    vec++;
    if (fpu_opc !== 3'd4) begin
      errs++;
      $display("FAIL illegal_opc_hold: got %0d want 4", fpu_opc);
    end
  endtask

  task automatic test_div_backpressure;
    int acc;
    do_op($urandom, $urandom, 3'd3, 10, 1'b0, acc);
  endtask

  task automatic test_reset_mid;
    int acc;
    int r;
    req_a = $urandom;
    req_b = $urandom;
    req_opc = 3'd3;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    exp_fa = req_a;
    exp_fb = req_b;
    exp_fo = 3'd3;
    repeat (14) @(negedge clk);
    vec++;
    if (busy !== 1'b1 || fpu_opc !== 3'd3) begin
      errs++;
      $display("FAIL mid_busy: busy=%b opc=%0d want 1/3", busy, fpu_opc);
    end
    rst = 1'b1;
    #1;
    exp_fa = '0;
    exp_fb = '0;
    exp_fo = '0;
    vec++;
    if ({req_ready, fpu_a, fpu_b, fpu_opc, rsp_valid, rsp_data, rsp_aeb,
         rsp_alb, rsp_agb, rsp_err, busy} !== '0) begin
      errs++;
      $display("FAIL mid_reset: rdy=%b opc=%0d v=%b busy=%b want 0",
               req_ready, fpu_opc, rsp_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    do_op($urandom, $urandom, 3'd2, 0, 1'b0, acc);
    vec++;
    if (acc != r + 1) begin
      errs++;
      $display("FAIL mul_after_rst: accept edge %0d want %0d", acc, r + 1);
    end
  endtask

  task automatic test_back_to_back;
    int acc[3];
    logic [2:0] ops[3];
    ops[0] = 3'd1;
    ops[1] = 3'd4;
    ops[2] = 3'd0;
    for (int i = 0; i < 3; i++)
      do_op($urandom, $urandom, ops[i], 0, (i < 2), acc[i]);
    for (int i = 1; i < 3; i++) begin
      vec++;
      if (acc[i] - acc[i-1] != latf(ops[i-1]) + 2) begin
        errs++;
        $display("FAIL b2b_spacing: got %0d want %0d",
                 acc[i] - acc[i-1], latf(ops[i-1]) + 2);
      end
    end
  endtask

  task automatic test_random;
    int acc;
    for (int i = 0; i < 24; i++)
      do_op($urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3), 1'($urandom), acc);
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_compare();
    test_illegal();
    test_div_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
